// File: rtl/eth_reg_bus_if_pkg.sv
// eth_reg_pkg: shared types and constants for the MAC register bus front-end.
//   FSM state encoding, register byte offsets, data width, bank size limit.
package eth_reg_pkg;

    localparam int ETH_REG_DW   = 32;
    localparam int ETH_MAX_REGS = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [7:0] MODER_ADR      = 8'h00;
    localparam logic [7:0] INT_SOURCE_ADR = 8'h04;
    localparam logic [7:0] INT_MASK_ADR   = 8'h08;
    localparam logic [7:0] IPGT_ADR       = 8'h0C;
    localparam logic [7:0] IPGR1_ADR      = 8'h10;
    localparam logic [7:0] IPGR2_ADR      = 8'h14;
    localparam logic [7:0] PACKETLEN_ADR  = 8'h18;
    localparam logic [7:0] COLLCONF_ADR   = 8'h1C;
    localparam logic [7:0] TX_BD_NUM_ADR  = 8'h20;
    localparam logic [7:0] CTRLMODER_ADR  = 8'h24;
    localparam logic [7:0] MIIMODER_ADR   = 8'h28;
    localparam logic [7:0] MIICOMMAND_ADR = 8'h2C;
    localparam logic [7:0] MIIADDRESS_ADR = 8'h30;
    localparam logic [7:0] MIITX_DATA_ADR = 8'h34;
    localparam logic [7:0] MIIRX_DATA_ADR = 8'h38;
    localparam logic [7:0] MIISTATUS_ADR  = 8'h3C;

endpackage

// File: rtl/eth_reg_bus_if_if.sv
// eth_wb_if: Wishbone slave bus bundle for the MAC register file.
//   Request: WbCycI, WbStbI, WbWeI, WbAdrI, WbSelI, WbDatI (master -> slave)
//   Response: WbDatO, WbAckO, WbErrO (slave -> master)
interface eth_wb_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic                  WbCycI;
    logic                  WbStbI;
    logic                  WbWeI;
    logic [ADDR_WIDTH-1:0] WbAdrI;
    logic [3:0]            WbSelI;
    logic [31:0]           WbDatI;
    logic [31:0]           WbDatO;
    logic                  WbAckO;
    logic                  WbErrO;

    modport slave (
        input  WbCycI, WbStbI, WbWeI, WbAdrI, WbSelI, WbDatI,
        output WbDatO, WbAckO, WbErrO
    );

    modport master (
        output WbCycI, WbStbI, WbWeI, WbAdrI, WbSelI, WbDatI,
        input  WbDatO, WbAckO, WbErrO
    );
endinterface

// File: rtl/eth_reg_bus_if_decode.sv
// eth_reg_decode: combinational byte address -> register index, validity, one-hot select.
//   adr    in   byte address
//   index  out  word index adr[ADDR_WIDTH-1:2]
//   valid  out  word aligned and inside the bank
//   onehot out  one-hot register select, zero when invalid
module eth_reg_decode #(
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic [ADDR_WIDTH-1:0] adr,
    output logic [ADDR_WIDTH-3:0] index,
    output logic                  valid,
    output logic [NUM_REGS-1:0]   onehot
);
    assign index  = adr[ADDR_WIDTH-1:2];
    assign valid  = (adr[1:0] == 2'b00) && (int'(index) < NUM_REGS);
    assign onehot = valid ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << index) : '0;
endmodule

// File: rtl/eth_reg_bus_if.sv
// eth_reg_bus_if: Wishbone slave front-end of the MAC register bank.
//   Clk, Reset          clock, async active-high reset
//   wb                  Wishbone slave port (request in, data/ack/err out)
//   RegWrite            per-register byte-lane write strobes, one cycle
//   RegRead             per-register read pulse, one cycle
//   RegDataOut          registered write data broadcast to the bank
//   RegDataIn           flattened register outputs, register r at [32r+31:32r]
module eth_reg_bus_if
    import eth_reg_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                           Clk,
    input  logic                           Reset,
    eth_wb_if.slave                        wb,
    output logic [NUM_REGS*4-1:0]          RegWrite,
    output logic [NUM_REGS-1:0]            RegRead,
    output logic [ETH_REG_DW-1:0]          RegDataOut,
    input  logic [NUM_REGS*ETH_REG_DW-1:0] RegDataIn
);
    localparam int IDX_W = ADDR_WIDTH - 2;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        index, idx_q;
    logic                    addr_ok, valid_q, we_q;
    logic [NUM_REGS-1:0]     onehot;
    logic                    accept, req_ok, finish;
    logic [ETH_REG_DW-1:0]   rd_data;
    logic [NUM_REGS*4-1:0]   write_n;
    logic [NUM_REGS-1:0]     read_n;
    logic [ETH_REG_DW-1:0]   data_out_n, dat_n;
    logic                    ack_n, err_n;

    eth_reg_decode #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .adr    (wb.WbAdrI),
        .index  (index),
        .valid  (addr_ok),
        .onehot (onehot)
    );

    // Strobes are registered at the accepting edge, so decode works on the live request.
    assign accept = (state == IDLE) && wb.WbCycI && wb.WbStbI;
    assign req_ok = addr_ok && (wb.WbSelI != 4'h0);
    assign finish = (state == ACCESS) && wb.WbCycI;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = (state == IDLE)   ? (accept ? ACCESS : IDLE) :
                  (state == ACCESS) ? (wb.WbCycI ? RESP : IDLE) : IDLE;
    end

    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (idx_q == IDX_W'(r)) rd_data = RegDataIn[r*ETH_REG_DW +: ETH_REG_DW];
        end
    end

    // Next values of the registered outputs; a cancelled access (cycle dropped) yields no response.
    always_comb begin
        write_n    = (accept && req_ok && wb.WbWeI) ? ({{(NUM_REGS*4-4){1'b0}}, wb.WbSelI} << {index, 2'b00}) : '0;
        read_n     = (accept && req_ok && !wb.WbWeI) ? onehot : '0;
        data_out_n = accept ? wb.WbDatI : RegDataOut;
        ack_n      = finish && valid_q;
        err_n      = finish && !valid_q;
        dat_n      = (finish && valid_q && !we_q) ? rd_data : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RegWrite   <= '0;
            RegRead    <= '0;
            RegDataOut <= '0;
            wb.WbAckO  <= 1'b0;
            wb.WbErrO  <= 1'b0;
            wb.WbDatO  <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
        end else begin
            RegWrite   <= write_n;
            RegRead    <= read_n;
            RegDataOut <= data_out_n;
            wb.WbAckO  <= ack_n;
            wb.WbErrO  <= err_n;
            wb.WbDatO  <= dat_n;
            if (accept) begin
                idx_q   <= index;
                valid_q <= req_ok;
                we_q    <= wb.WbWeI;
            end
        end
    end
endmodule

// File: doc/eth_reg_bus_if.md
# eth_reg_bus_if

Wishbone slave front-end of the MAC register file. It sits directly upstream of the bank of `eth_register` instances. It decodes host accesses into per-register, per-byte write strobes and a registered write-data bus. It selects the addressed register's output for reads and returns a single-cycle Ack or Err, with read-strobe pulses for read-to-clear status registers.

## Interface
Parameters:
- `NUM_REGS`, 16, number of 32-bit registers in the bank (max 64).
- `ADDR_WIDTH`, 8, byte-address width of `WbAdrI`.

Ports:
- `Clk`  in  1  single system clock; all logic on rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `WbCycI`  in  1  bus cycle valid.
- `WbStbI`  in  1  strobe / request.
- `WbWeI`  in  1  1 = write, 0 = read.
- `WbAdrI`  in  ADDR_WIDTH  byte address.
- `WbSelI`  in  4  byte-lane enables; bit i covers `[8i+7:8i]`.
- `WbDatI`  in  32  write data.
- `WbDatO`  out  32  read data; valid while `WbAckO` is high.
- `WbAckO`  out  1  one-cycle successful completion.
- `WbErrO`  out  1  one-cycle error completion.
- `RegWrite`  out  NUM_REGS*4  byte-lane write strobes; bit `4*r+i` is register r, lane i.
- `RegRead`  out  NUM_REGS  one-cycle read pulse per register.
- `RegDataOut`  out  32  registered write data to all registers.
- `RegDataIn`  in  NUM_REGS*32  flattened register outputs; register r at `[32r+31:32r]`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: on `WbCycI & WbStbI`, latch address, `WbWeI`, `WbSelI` and `WbDatI`, then go to ACCESS.
- Decode: index = `WbAdrI[ADDR_WIDTH-1:2]`. A request is valid when `WbAdrI[1:0]==0`, index < `NUM_REGS` and `WbSelI != 0`.
- ACCESS, valid write: `RegWrite` bits `{4*idx+3..4*idx}` = latched `WbSelI` for exactly this cycle. `RegDataOut` = latched data.
- ACCESS, valid read: `RegRead[idx]` pulses. `RegDataIn[idx]` is registered into `WbDatO` at the end of the cycle.
- ACCESS, invalid request: no strobes. `WbDatO` = 0.
- ACCESS → RESP, unless `WbCycI` is low. In that case go to IDLE with no response; a write strobe already issued still takes effect.
- RESP: `WbAckO` (valid request) or `WbErrO` (invalid request) is high for one cycle, never both. Then go to IDLE.
- `WbDatO` is cleared to 0 when leaving RESP.
- Back-to-back: a request still asserted in the IDLE cycle after RESP starts a new access. Masters must drop `WbStbI` in the cycle they sample ack or err.

## Timing
- Request sampled at edge E0. `RegWrite`/`RegRead` are high between E0 and E1, so registers update at E1. `WbAckO`/`WbErrO` are high between E1 and E2.
- Latency from request to response: 2 cycles. Throughput: one access per 3 cycles.
- All outputs are registered; there is no combinational path from Wishbone inputs to outputs.
- Reset values: `WbDatO`=0, `WbAckO`=0, `WbErrO`=0, `RegWrite`=0, `RegRead`=0, `RegDataOut`=0, state IDLE.
- Reset asserted mid-access clears all outputs immediately. The access is dropped, with no strobe and no response.
- A read of a register written by the immediately preceding access returns the new value, because the write lands at E1 of the earlier access.

## Structure
- Shared package `eth_reg_pkg`:
  - FSM state encoding;
  - register byte-offset constants (MODER 0x00, INT_SOURCE 0x04, INT_MASK 0x08, …);
  - `ETH_REG_DW = 32`;
  - a localparam for the maximum `NUM_REGS`.
- One sub-module, `eth_reg_decode`: combinational address → {index, valid, one-hot select}. It is reused by the verification address model.

## Test plan
- Write `0xDEADBEEF` to 0x08 with `WbSelI=4'hF` → `RegWrite[11:8]=4'hF` for one cycle, `RegDataOut=0xDEADBEEF`, `WbAckO` 2 cycles after the request, `WbErrO`=0.
- Read 0x04 with register 1 holding `0x0000_00A5` → `RegRead[1]` pulses, `WbDatO=0x000000A5` coincident with `WbAckO`.
- Partial write to 0x0C with `WbSelI=4'b0010` → only `RegWrite[13]` is high.
- Error cases, each giving `WbErrO` for one cycle, `WbAckO`=0, no strobes:
  - address 0x06 (misaligned);
  - address `4*NUM_REGS` (out of range);
  - `WbSelI=0`.
- Write then immediate read of the same register → read returns the written data. Response spacing is 3 cycles.
- Cancel and reset cases:
  - `WbCycI` dropped during ACCESS → no ack or err.
  - `Reset` pulsed during ACCESS → all outputs 0 at once, FSM in IDLE, next request serviced normally.
